// File: rtl/uart_cfg_seq.sv
// Configuration sequencer and host arbiter for the UART 16550 register port.
// Programs divisor, LCR, FCR and IER on start; otherwise passes host accesses through.
module uart_cfg_seq #(
    parameter int unsigned GAP      = 0,
    parameter bit          READBACK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] divisor,
    input  logic [6:0]  lcr_cfg,
    input  logic [7:0]  fcr_cfg,
    input  logic [7:0]  ier_cfg,
    input  logic        h_wr,
    input  logic        h_rd,
    input  logic [2:0]  h_addr,
    input  logic [7:0]  h_din,
    output logic        h_ready,
    output logic [7:0]  h_dout,
    output logic        wr_o,
    output logic        rd_o,
    output logic [2:0]  addr_o,
    output logic [7:0]  din_o,
    input  logic [7:0]  dout_i,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [3:0] GAP_L = 4'(GAP);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        W_LCRD = 4'd1,
        W_DLL  = 4'd2,
        W_DLM  = 4'd3,
        W_LCR  = 4'd4,
        W_FCR  = 4'd5,
        W_IER  = 4'd6,
        RD_REQ = 4'd7,
        RD_CHK = 4'd8,
        DONE   = 4'd9
    } state_t;

    state_t      state_r;
    state_t      state_s;
    state_t      nxt_s;
    logic [3:0]  gap_r;
    logic [3:0]  gap_s;
    logic        timed_s;
    logic        acc_wr_s;
    logic        acc_rd_s;
    logic [2:0]  acc_addr_s;
    logic [7:0]  acc_din_s;
    logic        seq_wr_s;
    logic        seq_rd_s;
    logic [2:0]  seq_addr_s;
    logic [7:0]  seq_din_s;
    logic        host_sel_s;
    logic [15:0] div_r;
    logic [6:0]  lcr_r;
    logic [7:0]  fcr_r;
    logic [7:0]  ier_r;
    logic        err_r;
    logic        busy_r;
    logic        done_r;

    function automatic logic lcr_mismatch(input logic [7:0] rd_data, input logic [6:0] lcr);
        return (rd_data != {1'b0, lcr});
    endfunction

    // Next-state, gap pacing and sequencer access decode.
    always_comb begin
        state_s    = state_r;
        gap_s      = gap_r;
        nxt_s      = IDLE;
        timed_s    = 1'b0;
        acc_wr_s   = 1'b0;
        acc_rd_s   = 1'b0;
        acc_addr_s = 3'd0;
        acc_din_s  = 8'd0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = W_LCRD;
                end else begin
                    state_s = IDLE;
                end
            end
            W_LCRD: begin
                timed_s = 1'b1; nxt_s = W_DLL;
                acc_wr_s = 1'b1; acc_addr_s = 3'd3; acc_din_s = {1'b1, lcr_r};
            end
            W_DLL: begin
                timed_s = 1'b1; nxt_s = W_DLM;
                acc_wr_s = 1'b1; acc_addr_s = 3'd0; acc_din_s = div_r[7:0];
            end
            W_DLM: begin
                timed_s = 1'b1; nxt_s = W_LCR;
                acc_wr_s = 1'b1; acc_addr_s = 3'd1; acc_din_s = div_r[15:8];
            end
            W_LCR: begin
                timed_s = 1'b1; nxt_s = W_FCR;
                acc_wr_s = 1'b1; acc_addr_s = 3'd3; acc_din_s = {1'b0, lcr_r};
            end
            W_FCR: begin
                timed_s = 1'b1; nxt_s = W_IER;
                acc_wr_s = 1'b1; acc_addr_s = 3'd2; acc_din_s = fcr_r;
            end
            W_IER: begin
                timed_s = 1'b1; nxt_s = READBACK ? RD_REQ : DONE;
                acc_wr_s = 1'b1; acc_addr_s = 3'd1; acc_din_s = ier_r;
            end
            RD_REQ: begin
                // Read data is due next cycle, so no gap between request and check.
                acc_rd_s = 1'b1; acc_addr_s = 3'd3;
                state_s  = RD_CHK;
            end
            RD_CHK: begin
                timed_s = 1'b1; nxt_s = DONE;
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                gap_s   = 4'd0;
            end
        endcase

        if (timed_s) begin
            if (gap_r == 4'd0) begin
                if (GAP_L == 4'd0) begin
                    state_s = nxt_s;
                end else begin
                    gap_s = GAP_L;
                end
            end else if (gap_r == 4'd1) begin
                state_s = nxt_s;
                gap_s   = 4'd0;
            end else begin
                gap_s = gap_r - 4'd1;
            end
        end else begin
            gap_s = 4'd0;
        end

        if (gap_r != 4'd0) begin
            seq_wr_s   = 1'b0;
            seq_rd_s   = 1'b0;
            seq_addr_s = 3'd0;
            seq_din_s  = 8'd0;
        end else begin
            seq_wr_s   = acc_wr_s;
            seq_rd_s   = acc_rd_s;
            seq_addr_s = acc_addr_s;
            seq_din_s  = acc_din_s;
        end
    end

    // Register port mux: host mirrored combinationally whenever it owns the bus.
    always_comb begin
        host_sel_s = (state_r == IDLE) && !start;
        wr_o       = 1'b0;
        rd_o       = 1'b0;
        addr_o     = 3'd0;
        din_o      = 8'd0;
        if (host_sel_s) begin
            wr_o = h_wr;
            rd_o = h_rd && !h_wr;
            if (h_wr || h_rd) begin
                addr_o = h_addr;
                din_o  = h_din;
            end else begin
                addr_o = 3'd0;
                din_o  = 8'd0;
            end
        end else begin
            wr_o   = seq_wr_s;
            rd_o   = seq_rd_s;
            addr_o = seq_addr_s;
            din_o  = seq_din_s;
        end
    end

    // State, pacing counter, latched configuration and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            gap_r   <= 4'd0;
            div_r   <= 16'd0;
            lcr_r   <= 7'd0;
            fcr_r   <= 8'd0;
            ier_r   <= 8'd0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            gap_r   <= gap_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
            if ((state_r == IDLE) && start) begin
                div_r <= divisor;
                lcr_r <= lcr_cfg;
                fcr_r <= fcr_cfg;
                ier_r <= ier_cfg;
                err_r <= 1'b0;
            end else if ((state_r == RD_CHK) && (gap_r == 4'd0)) begin
                err_r <= lcr_mismatch(dout_i, lcr_r);
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign h_ready = host_sel_s;
    assign h_dout  = dout_i;
    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;

endmodule

// File: tb/tb_uart_cfg_seq.sv
// Randomized self-checking bench for uart_cfg_seq: a cycle-stamped access
// log of the register port is compared with a spec-level timeline model.
module tb_uart_cfg_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, start_b;
    logic [15:0] divisor;
    logic [6:0]  lcr_cfg;
    logic [7:0]  fcr_cfg, ier_cfg;
    logic        h_wr, h_rd;
    logic [2:0]  h_addr;
    logic [7:0]  h_din;

    logic        h_ready_a, wr_a, rd_a, busy_a, done_a, err_a;
    logic [7:0]  h_dout_a, din_a, dout_a;
    logic [2:0]  addr_a;
    logic        h_ready_b, wr_b, rd_b, busy_b, done_b, err_b;
    logic [7:0]  h_dout_b, din_b, dout_b;
    logic [2:0]  addr_b;

    uart_cfg_seq #(.GAP(0), .READBACK(1'b1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .divisor(divisor), .lcr_cfg(lcr_cfg),
        .fcr_cfg(fcr_cfg), .ier_cfg(ier_cfg), .h_wr(h_wr), .h_rd(h_rd), .h_addr(h_addr),
        .h_din(h_din), .h_ready(h_ready_a), .h_dout(h_dout_a), .wr_o(wr_a), .rd_o(rd_a),
        .addr_o(addr_a), .din_o(din_a), .dout_i(dout_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    uart_cfg_seq #(.GAP(2), .READBACK(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .divisor(divisor), .lcr_cfg(lcr_cfg),
        .fcr_cfg(fcr_cfg), .ier_cfg(ier_cfg), .h_wr(h_wr), .h_rd(h_rd), .h_addr(h_addr),
        .h_din(h_din), .h_ready(h_ready_b), .h_dout(h_dout_b), .wr_o(wr_b), .rd_o(rd_b),
        .addr_o(addr_b), .din_o(din_b), .dout_i(dout_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         wr;
        logic [2:0] addr;
        logic [7:0] data;
    } acc_t;

    acc_t log_a[$];
    acc_t log_b[$];
    acc_t exp_q[$];

    // UART register stub: stores writes, answers reads one cycle later.
    logic [7:0] regs [8];
    bit         corrupt_rd = 1'b0;
    logic [7:0] corrupt_mask = 8'h80;
    initial dout_b = 8'h00;
    always @(posedge clk) begin
        if (wr_a === 1'b1) regs[addr_a] <= din_a;
        if (rd_a === 1'b1) dout_a <= (addr_a == 3'd3 && corrupt_rd) ? (regs[addr_a] ^ corrupt_mask) : regs[addr_a];
    end

    always @(negedge clk) begin
        if (rst === 1'b1 && (wr_a === 1'b1 || rd_a === 1'b1)) log_a.push_back(acc_t'{cyc, wr_a, addr_a, din_a});
        if (rst === 1'b1 && (wr_b === 1'b1 || rd_b === 1'b1)) log_b.push_back(acc_t'{cyc, wr_b, addr_b, din_b});
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Spec timeline: access i lands at start+1+i*(1+GAP); readback follows the last write's gap.
    function automatic void build_exp(input int s, input int g, input bit rb, input logic [15:0] dv,
                                      input logic [6:0] lc, input logic [7:0] fc, input logic [7:0] ie);
        logic [2:0] ad [6];
        logic [7:0] dt [6];
        ad = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd2, 3'd1};
        dt = '{{1'b1, lc}, dv[7:0], dv[15:8], {1'b0, lc}, fc, ie};
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(acc_t'{s + 1 + i * (1 + g), 1'b1, ad[i], dt[i]});
        if (rb) exp_q.push_back(acc_t'{s + 1 + 6 * (1 + g), 1'b0, 3'd3, 8'd0});
    endfunction

    function automatic int log_diff(input bit use_b);
        acc_t got[$];
        int   bad = 0;
        if (use_b) got = log_b; else got = log_a;
        if (got.size() != exp_q.size()) begin
            $display("  log size got %0d want %0d", got.size(), exp_q.size());
            bad++;
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            if (got[i].cyc != exp_q[i].cyc || got[i].wr != exp_q[i].wr || got[i].addr != exp_q[i].addr ||
                (exp_q[i].wr && got[i].data != exp_q[i].data)) begin
                $display("  entry %0d got cyc=%0d wr=%0b a=%0d d=%h want cyc=%0d wr=%0b a=%0d d=%h", i,
                         got[i].cyc, got[i].wr, got[i].addr, got[i].data,
                         exp_q[i].cyc, exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
                bad++;
            end
        end
        return bad;
    endfunction

    task automatic test_reset();
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0; h_wr = 1'b0; h_rd = 1'b0;
        h_addr = 3'd0; h_din = 8'd0; divisor = 16'd0; lcr_cfg = 7'd0; fcr_cfg = 8'd0; ier_cfg = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy_a, done_a, err_a, wr_a, rd_a} !== 5'b0) begin
            errors++; $display("FAIL reset_flags_a got %b want 00000", {busy_a, done_a, err_a, wr_a, rd_a});
        end
        checks++;
        if ({addr_a, din_a} !== 11'd0) begin
            errors++; $display("FAIL reset_bus_a got %h want 000", {addr_a, din_a});
        end
        checks++;
        if (h_ready_a !== 1'b1) begin
            errors++; $display("FAIL reset_h_ready got %b want 1", h_ready_a);
        end
        checks++;
        if ({busy_b, done_b, err_b, wr_b, rd_b} !== 5'b0) begin
            errors++; $display("FAIL reset_flags_b got %b want 00000", {busy_b, done_b, err_b, wr_b, rd_b});
        end
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({busy_a, done_a, err_a} !== 3'b0) begin
            errors++; $display("FAIL post_reset_idle got %b want 000", {busy_a, done_a, err_a});
        end
    endtask

    task automatic test_passthrough();
        log_a.delete();
        h_wr = 1'b1; h_rd = 1'b1; h_addr = 3'd5; h_din = 8'hAA;
        #1;
        checks++;
        if ({h_ready_a, wr_a, rd_a, addr_a, din_a} !== {1'b1, 1'b1, 1'b0, 3'd5, 8'hAA}) begin
            errors++; $display("FAIL pass_wr_wins got %b %b %b %h %h want 1 1 0 5 aa", h_ready_a, wr_a, rd_a, addr_a, din_a);
        end
        h_wr = 1'b0; h_addr = 3'd6;
        #1;
        checks++;
        if ({wr_a, rd_a, addr_a} !== {1'b0, 1'b1, 3'd6}) begin
            errors++; $display("FAIL pass_rd got %b %b %h want 0 1 6", wr_a, rd_a, addr_a);
        end
        tick();
        h_rd = 1'b0; h_addr = 3'd0; h_din = 8'd0;
        tick();
    endtask

    task automatic test_random_seq(input bit fixed, input bit corrupt);
        logic [15:0] dv;
        logic [6:0]  lc;
        logic [7:0]  fc, ie;
        int s, dexp, dc, busy_bad;
        if (fixed) begin
            dv = 16'h0108; lc = 7'h03; fc = 8'h07; ie = 8'h01; corrupt_mask = 8'h80;
        end else begin
            dv = 16'($urandom); lc = 7'($urandom); fc = 8'($urandom); ie = 8'($urandom);
            corrupt_mask = 8'(8'h01 << $urandom_range(0, 7));
        end
        corrupt_rd = corrupt;
        log_a.delete();
        divisor = dv; lcr_cfg = lc; fcr_cfg = fc; ier_cfg = ie;
        s = cyc; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        divisor = ~dv; lcr_cfg = ~lc; fcr_cfg = ~fc; ier_cfg = ~ie;
        build_exp(s, 0, 1'b1, dv, lc, fc, ie);
        dexp = s + 9; dc = -1; busy_bad = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (busy_a !== ((cyc > s && cyc <= dexp) ? 1'b1 : 1'b0)) busy_bad++;
            if (done_a === 1'b1 && dc < 0) begin
                dc = cyc;
                checks++;
                if (err_a !== corrupt) begin
                    errors++; $display("FAIL seq_err_at_done got %b want %b", err_a, corrupt);
                end
            end
        end
        checks++;
        if (dc != dexp) begin
            errors++; $display("FAIL seq_done_cycle got %0d want %0d", dc, dexp);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++; $display("FAIL seq_busy_window got %0d bad cycles want 0", busy_bad);
        end
        checks++;
        if (log_diff(1'b0) != 0) begin
            errors++; $display("FAIL seq_access_log got mismatches want none");
        end
        checks++;
        if (err_a !== corrupt) begin
            errors++; $display("FAIL seq_err_sticky got %b want %b", err_a, corrupt);
        end
        tick();
    endtask

    task automatic test_gap();
        int s, dexp, dc, busy_bad;
        log_b.delete();
        divisor = 16'h0108; lcr_cfg = 7'h03; fcr_cfg = 8'h07; ier_cfg = 8'h01;
        s = cyc; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        build_exp(s, 2, 1'b0, 16'h0108, 7'h03, 8'h07, 8'h01);
        dexp = s + 19; dc = -1; busy_bad = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (busy_b !== ((cyc > s && cyc <= dexp) ? 1'b1 : 1'b0)) busy_bad++;
            if (done_b === 1'b1 && dc < 0) dc = cyc;
        end
        checks++;
        if (dc != dexp) begin
            errors++; $display("FAIL gap_done_cycle got %0d want %0d", dc, dexp);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++; $display("FAIL gap_busy_window got %0d bad cycles want 0", busy_bad);
        end
        checks++;
        if (log_diff(1'b1) != 0) begin
            errors++; $display("FAIL gap_access_log got mismatches want none");
        end
        checks++;
        if (err_b !== 1'b0) begin
            errors++; $display("FAIL gap_err got %b want 0", err_b);
        end
        tick();
    endtask

    task automatic test_host_stall();
        logic [15:0] dv;
        logic [6:0]  lc;
        logic [7:0]  fc, ie;
        int s, dc, acc;
        dv = 16'($urandom); lc = 7'($urandom); fc = 8'($urandom); ie = 8'($urandom);
        corrupt_rd = 1'b0;
        log_a.delete();
        divisor = dv; lcr_cfg = lc; fcr_cfg = fc; ier_cfg = ie;
        s = cyc; start_a = 1'b1;
        tick();
        start_a = 1'b0; h_wr = 1'b1; h_addr = 3'd7; h_din = 8'h5A;
        build_exp(s, 0, 1'b1, dv, lc, fc, ie);
        exp_q.push_back(acc_t'{s + 10, 1'b1, 3'd7, 8'h5A});
        dc = -1; acc = -1;
        for (int i = 0; i < 30 && acc < 0; i++) begin
            @(negedge clk);
            if (done_a === 1'b1) dc = cyc;
            if (h_ready_a === 1'b1) acc = cyc;
        end
        checks++;
        if ({wr_a, addr_a, din_a} !== {1'b1, 3'd7, 8'h5A}) begin
            errors++; $display("FAIL stall_host_write got %b %h %h want 1 7 5a", wr_a, addr_a, din_a);
        end
        tick();
        h_wr = 1'b0; h_addr = 3'd0; h_din = 8'd0;
        tick();
        checks++;
        if (acc != s + 10) begin
            errors++; $display("FAIL stall_accept_cycle got %0d want %0d", acc, s + 10);
        end
        checks++;
        if (dc != s + 9) begin
            errors++; $display("FAIL stall_done_cycle got %0d want %0d", dc, s + 9);
        end
        checks++;
        if (log_diff(1'b0) != 0) begin
            errors++; $display("FAIL stall_access_log got mismatches want none");
        end
    endtask

    task automatic test_start_host_rd();
        logic [15:0] dv;
        logic [6:0]  lc;
        logic [7:0]  fc, ie;
        int s, dc, acc;
        dv = 16'($urandom); lc = 7'($urandom); fc = 8'($urandom); ie = 8'($urandom);
        corrupt_rd = 1'b0;
        log_a.delete();
        divisor = dv; lcr_cfg = lc; fcr_cfg = fc; ier_cfg = ie;
        s = cyc; start_a = 1'b1; h_rd = 1'b1; h_addr = 3'd3; h_din = 8'h00;
        @(negedge clk);
        checks++;
        if ({h_ready_a, wr_a, rd_a} !== 3'b000) begin
            errors++; $display("FAIL race_start_wins got %b want 000", {h_ready_a, wr_a, rd_a});
        end
        tick();
        start_a = 1'b0;
        checks++;
        if (err_a !== 1'b0) begin
            errors++; $display("FAIL race_err_cleared got %b want 0", err_a);
        end
        tick(); tick();
        start_a = 1'b1; divisor = ~dv; lcr_cfg = ~lc; fcr_cfg = ~fc; ier_cfg = ~ie;
        tick();
        start_a = 1'b0;
        build_exp(s, 0, 1'b1, dv, lc, fc, ie);
        exp_q.push_back(acc_t'{s + 10, 1'b0, 3'd3, 8'd0});
        dc = -1; acc = -1;
        for (int i = 0; i < 30 && acc < 0; i++) begin
            @(negedge clk);
            if (done_a === 1'b1) dc = cyc;
            if (h_ready_a === 1'b1) acc = cyc;
        end
        checks++;
        if ({wr_a, rd_a, addr_a} !== {1'b0, 1'b1, 3'd3}) begin
            errors++; $display("FAIL race_host_read got %b %b %h want 0 1 3", wr_a, rd_a, addr_a);
        end
        tick();
        h_rd = 1'b0; h_addr = 3'd0;
        @(negedge clk);
        checks++;
        if (h_dout_a !== {1'b0, lc}) begin
            errors++; $display("FAIL race_h_dout got %h want %h", h_dout_a, {1'b0, lc});
        end
        checks++;
        if (dc != s + 9) begin
            errors++; $display("FAIL race_done_cycle got %0d want %0d", dc, s + 9);
        end
        checks++;
        if (acc != s + 10) begin
            errors++; $display("FAIL race_accept_cycle got %0d want %0d", acc, s + 10);
        end
        checks++;
        if (log_diff(1'b0) != 0) begin
            errors++; $display("FAIL race_access_log got mismatches want none");
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [15:0] dv;
        int s, dn;
        checks++;
        if (err_a !== 1'b1) begin
            errors++; $display("FAIL pre_reset_err_sticky got %b want 1", err_a);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (err_a !== 1'b0) begin
            errors++; $display("FAIL reset_clears_err got %b want 0", err_a);
        end
        #1 rst = 1'b1;
        tick();
        dv = 16'($urandom);
        divisor = dv; lcr_cfg = 7'($urandom); fcr_cfg = 8'($urandom); ier_cfg = 8'($urandom);
        s = cyc; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick(); tick();
        checks++;
        if ({wr_a, addr_a, din_a} !== {1'b1, 3'd1, dv[15:8]}) begin
            errors++; $display("FAIL mid_w_dlm got %b %h %h want 1 1 %h (start %0d)", wr_a, addr_a, din_a, dv[15:8], s);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({busy_a, done_a, err_a, wr_a, rd_a, h_ready_a} !== 6'b000001) begin
            errors++; $display("FAIL mid_reset_flags got %b want 000001", {busy_a, done_a, err_a, wr_a, rd_a, h_ready_a});
        end
        checks++;
        if ({addr_a, din_a} !== 11'd0) begin
            errors++; $display("FAIL mid_reset_bus got %h want 000", {addr_a, din_a});
        end
        #1 rst = 1'b1;
        log_a.delete();
        dn = 0;
        repeat (15) begin
            @(negedge clk);
            if (done_a === 1'b1) dn++;
        end
        checks++;
        if (dn != 0 || log_a.size() != 0) begin
            errors++; $display("FAIL mid_reset_abort got done=%0d accesses=%0d want 0 0", dn, log_a.size());
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_random_seq(1'b1, 1'b0);
        test_random_seq(1'b1, 1'b1);
        for (int k = 0; k < 4; k++) test_random_seq(1'b0, 1'($urandom_range(0, 1)));
        test_gap();
        test_host_stall();
        test_random_seq(1'b0, 1'b1);
        test_start_host_rd();
        test_random_seq(1'b0, 1'b1);
        test_reset_mid();
        test_random_seq(1'b1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_cfg_seq.md
# uart_cfg_seq

Register-bus configuration sequencer and arbiter for the UART 16550 register block. On a `start` pulse it programs the divisor latch (LCR.DLAB=1, DLL, DLM), restores LCR with DLAB=0, writes FCR and IER, and optionally reads LCR back to verify it. Outside a sequence it passes a host register bus straight through to the UART register port. It sits between the system host and the UART register block's `wr_i/rd_i/addr_i/din_i/dout_o` port.

## Interface
- `GAP`, 0: idle cycles inserted between consecutive sequencer accesses (0–15).
- `READBACK`, 1: 1 = read back LCR after programming and compare; 0 = skip.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to run the configuration sequence.
- `divisor` in 16: baud divisor; [7:0] to DLL, [15:8] to DLM.
- `lcr_cfg` in 7: LCR bits [6:0]; bit 7 (DLAB) is generated internally.
- `fcr_cfg` in 8: value written to FCR (addr 2).
- `ier_cfg` in 8: value written to IER (addr 1, DLAB=0).
- `h_wr`, `h_rd` in 1: host write/read request; held until accepted.
- `h_addr` in 3, `h_din` in 8: host address and write data.
- `h_ready` out 1: host request is accepted in this cycle.
- `h_dout` out 8: read data to the host, equal to `dout_i`.
- `wr_o`, `rd_o` out 1: register-port write/read strobes.
- `addr_o` out 3, `din_o` out 8: register-port address and write data.
- `dout_i` in 8: register-port read data, valid one cycle after `rd_o`.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle pulse at sequence end.
- `err` out 1: sticky LCR readback mismatch; cleared by the next accepted `start`.

## Operation
- States: IDLE, W_LCRD, W_DLL, W_DLM, W_LCR, W_FCR, W_IER, RD_REQ, RD_CHK, DONE.
- IDLE:
  - `start`=1 latches `divisor`, `lcr_cfg`, `fcr_cfg` and `ier_cfg`, clears `err`, and moves to W_LCRD.
  - `start` while not IDLE is ignored.
- Write states each drive `wr_o`=1 for exactly one cycle:
  - W_LCRD: addr 3, data {1,lcr}.
  - W_DLL: addr 0, data div[7:0].
  - W_DLM: addr 1, data div[15:8].
  - W_LCR: addr 3, data {0,lcr}.
  - W_FCR: addr 2, data fcr.
  - W_IER: addr 1, data ier.
- Between accesses, a 4-bit gap counter holds `wr_o`/`rd_o` low for GAP cycles.
- After W_IER:
  - If READBACK=1, go to RD_REQ. RD_REQ drives `rd_o`=1 with addr 3 for one cycle. RD_CHK samples `dout_i` and sets `err` if it differs from {0,lcr}.
  - If READBACK=0, go to DONE.
- DONE: `done`=1 for one cycle, then return to IDLE.
- Arbitration:
  - `h_ready` = (state==IDLE) && !`start`. A simultaneous `start` beats the host.
  - When `h_ready`=1, the port mirrors the host combinationally: `wr_o`=`h_wr`, `rd_o`=`h_rd`, `addr_o`=`h_addr`, `din_o`=`h_din`.
  - When the host is not selected, the host is stalled and never sees a partial access.
- `h_wr`&&`h_rd` together: the write wins and `rd_o` stays 0.

## Timing
- Reset values:
  - State IDLE and gap counter 0.
  - `busy`, `done`, `err` = 0.
  - `wr_o`, `rd_o` = 0, except during host pass-through, where they follow the host inputs.
  - `addr_o`, `din_o` = 0 when no host request is present.
- `busy`=1 from the cycle after `start` acceptance through the DONE cycle.
- Latency from `start` to `done`:
  - READBACK=1: 9 + 7·GAP cycles.
  - READBACK=0: 7 + 6·GAP cycles.
- Host access has zero added latency in IDLE.
- Reset asserted mid-sequence aborts immediately: IDLE, no `done`, `err` cleared. The UART may be left with DLAB=1; the host must rerun the sequence.
- `err` updates in the RD_CHK cycle and is visible in DONE.

## Test plan
- GAP=0, divisor=0x0108, lcr=0x03, fcr=0x07, ier=0x01 -> writes (3,0x83),(0,0x08),(1,0x01),(3,0x03),(2,0x07),(1,0x01) on consecutive cycles, then `rd_o` at addr 3; `done` 9 cycles after `start`, `err`=0.
- Same run with the model returning 0x83 on readback -> `err`=1 in DONE and held until the next `start`.
- GAP=2, READBACK=0 -> exactly 2 idle cycles between each write; `done` 19 cycles after `start`.
- `h_wr` held with addr 7, data 0x5A during a sequence -> `h_ready`=0 until IDLE, then a single write of 0x5A to addr 7.
- `start` and `h_rd` in the same IDLE cycle -> sequence wins and the host read completes after `done`; a second `start` mid-sequence is ignored.
- `rst` asserted low in W_DLM -> all outputs return to reset values asynchronously; after release, a new `start` runs the full sequence.
